// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with alignment check,
// req/ack data-memory port, load extension and request timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [3:0]  i_mem_op,
  input  logic [31:0] i_eff_addr,
  input  logic [1:0]  i_addr_exception,
  input  logic [31:0] i_store_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_misaligned,
  output logic        o_bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;  // 0 byte, 1 half, 2 word
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic [1:0]  in_size;
  logic        in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    in_size       = (i_mem_op[1:0] == 2'b00) ? 2'd0 :
                    (i_mem_op[1:0] == 2'b01) ? 2'd1 : 2'd2;
    in_misaligned = ((in_size == 2'd1) && i_addr_exception[0]) ||
                    ((in_size == 2'd2) && (i_addr_exception != 2'b00));
    in_be         = 4'b1111;
    in_wdata      = i_store_data;
    case (in_size)
      2'd0: begin
        in_be    = 4'b0001 << i_eff_addr[1:0];
        in_wdata = {4{i_store_data[7:0]}};
      end
      2'd1: begin
        in_be    = i_eff_addr[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the latched low address, not the live AGU input.
  always_comb begin
    rd_byte = i_mem_rdata[7:0];
    case (lane_q)
      2'd1:    rd_byte = i_mem_rdata[15:8];
      2'd2:    rd_byte = i_mem_rdata[23:16];
      2'd3:    rd_byte = i_mem_rdata[31:24];
      default: ;
    endcase
    rd_half = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (size_q)
      2'd0:    rd_ext = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
      2'd1:    rd_ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
      default: rd_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    cnt_d     = 8'd0;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (in_misaligned) begin
            bus_err_d = 1'b0;
            state_d   = ERR;
          end else begin
            addr_d  = i_eff_addr[31:2];
            lane_d  = i_eff_addr[1:0];
            size_d  = in_size;
            we_d    = i_mem_op[3];
            uns_d   = i_mem_op[2];
            be_d    = in_be;
            wdata_d = in_wdata;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          load_d  = we_q ? 32'd0 : rd_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          bus_err_d = 1'b1;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign o_mem_req    = (state_q == REQ);
  assign o_mem_we     = (state_q == REQ) & we_q;
  assign o_mem_addr   = {addr_q, 2'b00};
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_busy       = ((state_q == IDLE) & i_valid) | (state_q == REQ);
  assign o_done       = (state_q == DONE);
  assign o_load_data  = (state_q == DONE) ? load_q : 32'd0;
  assign o_misaligned = (state_q == ERR) & ~bus_err_q;
  assign o_bus_error  = (state_q == ERR) & bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] eff = 32'd0;
  logic [1:0]  exc = 2'd0;
  logic [31:0] sd = 32'd0;
  logic        req, we, ack, busy, done, misal, berr;
  logic [31:0] maddr, wdata, rdata, ldata;
  logic [3:0]  be;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_mem_op(op),
    .i_eff_addr(eff), .i_addr_exception(exc), .i_store_data(sd),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(maddr), .o_mem_be(be),
    .o_mem_wdata(wdata), .i_mem_ack(ack), .i_mem_rdata(rdata),
    .o_busy(busy), .o_done(done), .o_load_data(ldata),
    .o_misaligned(misal), .o_bus_error(berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    valid = 1'b1; op = o; eff = a; exc = a[1:0]; sd = d;
    @(negedge clk);
    chk("busy_c0", busy, 1);
    chk("req_c0", req, 0);
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] d, input int waits, input logic [31:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic exp_we, input logic [31:0] exp_ld);
    issue(o, a, d);
    @(posedge clk); #1;
    valid = 1'b0;
    ack   = (waits == 0);
    rdata = ack ? rd : 32'h5A5A_5A5A;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({name, "_req"}, req, 1);
      chk({name, "_addr"}, maddr, {a[31:2], 2'b00});
      chk({name, "_be"}, be, exp_be);
      chk({name, "_wdata"}, wdata, exp_wd);
      chk({name, "_we"}, we, exp_we);
      chk({name, "_busy"}, busy, 1);
      chk({name, "_nodone"}, done, 0);
      @(posedge clk); #1;
      ack   = (i + 1 == waits);
      rdata = ack ? rd : 32'h5A5A_5A5A;
    end
    @(negedge clk);
    chk({name, "_done"}, done, 1);
    chk({name, "_ldata"}, ldata, exp_ld);
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_req_done"}, req, 0);
    chk({name, "_noerr"}, {30'd0, misal, berr}, 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
  endtask

  task automatic run_misaligned(input string name, input logic [3:0] o, input logic [31:0] a);
    issue(o, a, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk({name, "_misal"}, misal, 1);
    chk({name, "_berr"}, berr, 0);
    chk({name, "_req"}, req, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    @(negedge clk);
    chk({name, "_misal_pulse"}, misal, 0);
    chk({name, "_req_after"}, req, 0);
  endtask

  initial begin
    int reqcnt, berrcnt, berr_at, donecnt, misalcnt;
    ack = 1'b0;
    rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {30'd0, misal, berr}, 0);
    chk("rst_ldata", ldata, 0);
    chk("rst_be", be, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("lw",  4'b0011, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
    run_op("lb",  4'b0000, 32'h0000_1003, 32'h1122_3344, 0, 32'h8000_0000, 4'b1000, 32'h4444_4444, 1'b0, 32'hFFFF_FF80);
    run_op("lbu", 4'b0100, 32'h0000_1003, 32'h1122_3344, 0, 32'h8000_0000, 4'b1000, 32'h4444_4444, 1'b0, 32'h0000_0080);
    run_op("lh",  4'b0001, 32'h0000_1002, 32'h1122_3344, 0, 32'h8001_0000, 4'b1100, 32'h3344_3344, 1'b0, 32'hFFFF_8001);
    run_op("lhu", 4'b0101, 32'h0000_1000, 32'h0, 1, 32'h1234_F00D, 4'b0011, 32'h0, 1'b0, 32'h0000_F00D);
    run_op("lb1", 4'b0000, 32'h0000_1001, 32'h0, 0, 32'h0000_7F00, 4'b0010, 32'h0, 1'b0, 32'h0000_007F);
    run_op("sh",  4'b1001, 32'h0000_2002, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0);
    run_op("sb",  4'b1000, 32'h0000_3001, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0);
    run_op("lw10", 4'b0010, 32'h0000_3008, 32'h0, 2, 32'h8765_4321, 4'b1111, 32'h0, 1'b0, 32'h8765_4321);

    run_misaligned("mis_lw", 4'b0011, 32'h0000_1006);
    run_misaligned("mis_lh", 4'b0001, 32'h0000_1001);

    // Timeout: ack withheld, then a late ack once the unit is idle again.
    issue(4'b0011, 32'h0000_4000, 32'h0);
    reqcnt = 0; berrcnt = 0; berr_at = -1; donecnt = 0; misalcnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      ack   = (i == 17 || i == 18);
      rdata = 32'hCAFE_F00D;
      @(negedge clk);
      if (req)   reqcnt++;
      if (berr)  begin berrcnt++; berr_at = i; end
      if (done)  donecnt++;
      if (misal) misalcnt++;
    end
    ack = 1'b0;
    chk("to_req_cycles", reqcnt, 16);
    chk("to_berr_count", berrcnt, 1);
    chk("to_berr_cycle", berr_at, 16);
    chk("to_no_done", donecnt, 0);
    chk("to_no_misal", misalcnt, 0);

    // Reset during the second REQ cycle with an ack arriving in the same cycle.
    issue(4'b0011, 32'h0000_5000, 32'h0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("rm_req_c1", req, 1);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'h1111_2222;
    #2;
    rst = 1'b1;
    #1;
    chk("rm_req_async", req, 0);
    chk("rm_done_async", done, 0);
    @(posedge clk); #1;
    ack = 1'b0;
    rst = 1'b0;
    donecnt = 0; berrcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) donecnt++;
      if (berr) berrcnt++;
      if (req)  reqcnt++;
    end
    chk("rm_no_done", donecnt, 0);
    chk("rm_no_berr", berrcnt, 0);
    chk("rm_req_idle", reqcnt, 16);
    run_op("lw_post", 4'b0011, 32'h0000_6004, 32'h0, 0, 32'h0BAD_CAFE, 4'b1111, 32'h0, 1'b0, 32'h0BAD_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
